// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the memory stage: M/W bundles, FSM states,
// the W-stage bubble constant and small bundle helpers.
package pipeline_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            result_src;
    logic            wd_mem;
    logic            is_load;
    logic            wd3_src;
  } m_bundle_t;

  typedef struct packed {
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic            reg_write;
    logic            result_src;
    logic            wd3_src;
  } w_bundle_t;

  localparam w_bundle_t W_NOP = '0;

  function automatic logic is_access(m_bundle_t m);
    return m.is_load | m.wd_mem;
  endfunction

  // load wins when both enables are (illegally) set
  function automatic logic is_store(m_bundle_t m);
    return m.wd_mem & ~m.is_load;
  endfunction

  function automatic w_bundle_t to_wb(
    m_bundle_t       m,
    logic [XLEN-1:0] rdata
  );
    w_bundle_t w;
    w.read_data  = m.is_load ? rdata : '0;
    w.alu_result = m.alu_result;
    w.pc_plus4   = m.pc_plus4;
    w.rd         = m.rd;
    w.reg_write  = m.reg_write;
    w.result_src = m.result_src;
    w.wd3_src    = m.wd3_src;
    return w;
  endfunction

endpackage

// File: rtl/pipeline_MEMtoWB.sv
// MEM->WB pipeline register: loads the completed result each cycle,
// or a bubble while the memory access is outstanding.
module pipeline_MEMtoWB
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  m_bundle_t       src_i,
  input  logic [XLEN-1:0] rdata_i,
  input  logic            bubble_i,
  output w_bundle_t       w_o
);

  w_bundle_t w_d;
  w_bundle_t w_q;

  always_comb begin
    w_d = to_wb(src_i, rdata_i);
    if (bubble_i) w_d = W_NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_q <= W_NOP;
    else        w_q <= w_d;
  end

  assign w_o = w_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory req/ack accesses and stalls until ack.
// Optional WAIT timeout with sticky mem_err enabled by MEM_TIMEOUT_EN.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  input  logic [WIDTH-1:0] PCPlus4M,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             ResultSrcM,
  input  logic             WDMEM,
  input  logic             isLoadM,
  input  logic             WD3SrcM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             stall_o,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUResultW,
  output logic [WIDTH-1:0] PCPlus4W,
  output logic [4:0]       RdW,
  output logic             RegWriteW,
  output logic             ResultSrcW,
  output logic             WD3SrcW
`ifdef MEM_TIMEOUT_EN
  ,
  output logic             mem_err
`endif
);

  if (WIDTH != XLEN) begin : g_width_chk
    $error("WIDTH must equal pipeline_pkg::XLEN");
  end

  mem_state_t state_q, state_d;
  m_bundle_t  hold_q, hold_d;
  m_bundle_t  m_in;
  m_bundle_t  cur;
  w_bundle_t  w_out;
  logic       req_c;
  logic       stall_c;
  logic       bubble_c;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    m_in.alu_result = ALUResultM;
    m_in.write_data = WriteDataM;
    m_in.pc_plus4   = PCPlus4M;
    m_in.rd         = RdM;
    m_in.reg_write  = RegWriteM;
    m_in.result_src = ResultSrcM;
    m_in.wd_mem     = WDMEM;
    m_in.is_load    = isLoadM;
    m_in.wd3_src    = WD3SrcM;
  end

  // in WAIT the M inputs are bubbles; everything comes from the hold reg
  assign cur = (state_q == WAIT) ? hold_q : m_in;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    req_c    = 1'b0;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        hold_d = m_in;
        if (is_access(m_in)) begin
          req_c = 1'b1;
          if (!mem_ack) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            state_d  = WAIT;
`ifdef MEM_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      WAIT: begin
        req_c = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
        end else begin
          bubble_c = 1'b1;
`ifdef MEM_TIMEOUT_EN
          if (cnt_q == LIM) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = cnt_q + 1'b1;
          end
`else
          stall_c = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`endif

  // reset must silence the bus even if M shows an access
  assign mem_req   = req_c & rst_n;
  assign stall_o   = stall_c & rst_n;
  assign mem_we    = mem_req & is_store(cur);
  assign mem_addr  = mem_req ? cur.alu_result : '0;
  assign mem_wdata = mem_req ? cur.write_data : '0;

  pipeline_MEMtoWB u_memtowb (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_i    (cur),
    .rdata_i  (mem_rdata),
    .bubble_i (bubble_c),
    .w_o      (w_out)
  );

  assign ReadDataW  = w_out.read_data;
  assign ALUResultW = w_out.alu_result;
  assign PCPlus4W   = w_out.pc_plus4;
  assign RdW        = w_out.rd;
  assign RegWriteW  = w_out.reg_write;
  assign ResultSrcW = w_out.result_src;
  assign WD3SrcW    = w_out.wd3_src;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random
// instruction streams against a per-instruction latency model.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, ResultSrcM, WDMEM, isLoadM, WD3SrcM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_o;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W;
  logic [4:0]  RdW;
  logic        RegWriteW, ResultSrcW, WD3SrcW;
`ifdef MEM_TIMEOUT_EN
  logic        mem_err;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] alu, wd, pc;
    logic [4:0]  rd;
    logic        rw, rs, wdm, ld, w3;
  } instr_t;

  mem_access_stage #(.WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
    .WDMEM(WDMEM), .isLoadM(isLoadM), .WD3SrcM(WD3SrcM),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_o(stall_o),
    .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .PCPlus4W(PCPlus4W), .RdW(RdW),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .WD3SrcW(WD3SrcW)
`ifdef MEM_TIMEOUT_EN
    , .mem_err(mem_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] w_now();
    return {ReadDataW, ALUResultW, PCPlus4W, RdW,
            RegWriteW, ResultSrcW, WD3SrcW};
  endfunction

  function automatic logic [127:0] w_exp(
    input instr_t t,
    input logic [31:0] rdata
  );
    logic [31:0] rd_val;
    rd_val = t.ld ? rdata : 32'h0;
    return {rd_val, t.alu, t.pc, t.rd, t.rw, t.rs, t.w3};
  endfunction

  task automatic drive(input instr_t t);
    ALUResultM = t.alu;
    WriteDataM = t.wd;
    PCPlus4M   = t.pc;
    RdM        = t.rd;
    RegWriteM  = t.rw;
    ResultSrcM = t.rs;
    WDMEM      = t.wdm;
    isLoadM    = t.ld;
    WD3SrcM    = t.w3;
  endtask

  function automatic instr_t rnd_instr(input int kind);
    instr_t t;
    t.alu = $urandom;
    t.wd  = $urandom;
    t.pc  = $urandom;
    t.rd  = 5'($urandom_range(0, 31));
    t.rw  = 1'($urandom_range(0, 1));
    t.rs  = 1'($urandom_range(0, 1));
    t.w3  = 1'($urandom_range(0, 1));
    t.ld  = (kind == 1) || (kind == 3);
    t.wdm = (kind == 2) || (kind == 3);
    if (kind == 2) t.rw = 1'b0;
    return t;
  endfunction

  function automatic instr_t zero_instr();
    instr_t t;
    t = '{32'h0, 32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    return t;
  endfunction

  // one instruction: lat cycles without ack (stalled, bubble into W),
  // then the ack cycle which delivers the result
  task automatic run_instr(
    input instr_t      t,
    input int          lat,
    input logic [31:0] rdata
  );
    logic acc;
    int   n;
    acc = t.ld | t.wdm;
    n   = acc ? lat : 0;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      if (c == 0) drive(t);
      else        drive(rnd_instr($urandom_range(0, 3)));
      mem_ack   = acc ? (c == n) : 1'($urandom_range(0, 1));
      mem_rdata = (c == n) ? rdata : $urandom;
      #1;
      check_eq("mem_req", 128'(mem_req), 128'(acc));
      check_eq("stall", 128'(stall_o), 128'(acc && (c < n)));
      if (acc) begin
        check_eq("mem_addr", 128'(mem_addr), 128'(t.alu));
        check_eq("mem_we", 128'(mem_we), 128'(t.wdm & ~t.ld));
        if (t.wdm && !t.ld)
          check_eq("mem_wdata", 128'(mem_wdata), 128'(t.wd));
      end
      @(posedge clk);
      #1;
      if (c < n) check_eq("w_bubble", w_now(), 128'h0);
      else       check_eq("w_result", w_now(), w_exp(t, rdata));
    end
  endtask

  instr_t t;

  initial begin
    rst_n = 1'b0;
    drive(zero_instr());
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    #12;
    check_eq("rst_req", 128'(mem_req), 128'h0);
    check_eq("rst_stall", 128'(stall_o), 128'h0);
    check_eq("rst_w", w_now(), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    t = zero_instr();
    t.alu = 32'h10; t.rd = 5'd5; t.rw = 1'b1;
    run_instr(t, 0, 32'hFFFF_0000);

    t = zero_instr();
    t.ld = 1'b1; t.alu = 32'h100; t.rd = 5'd7; t.rw = 1'b1;
    t.rs = 1'b1; t.pc = 32'h44;
    run_instr(t, 0, 32'hDEADBEEF);

    t.rd = 5'd9;
    run_instr(t, 3, 32'hCAFE_F00D);

    t = zero_instr();
    t.wdm = 1'b1; t.alu = 32'h200; t.wd = 32'h12345678;
    run_instr(t, 2, 32'h5555_AAAA);
    t = zero_instr();
    t.ld = 1'b1; t.alu = 32'h300; t.rd = 5'd3; t.rw = 1'b1;
    run_instr(t, 0, 32'h0BAD_CAFE);

    t = zero_instr();
    t.rw = 1'b1;
    run_instr(t, 0, 32'h1);

    // reset while waiting on a load
    t = zero_instr();
    t.ld = 1'b1; t.alu = 32'h400; t.rd = 5'd12; t.rw = 1'b1;
    @(negedge clk);
    drive(t);
    mem_ack = 1'b0;
    #1;
    check_eq("rw_issue_stall", 128'(stall_o), 128'h1);
    @(negedge clk);
    drive(zero_instr());
    #1;
    check_eq("rw_wait_req", 128'(mem_req), 128'h1);
    check_eq("rw_wait_addr", 128'(mem_addr), 128'h400);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rw_rst_req", 128'(mem_req), 128'h0);
    check_eq("rw_rst_stall", 128'(stall_o), 128'h0);
    check_eq("rw_rst_w", w_now(), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rw_after_w", w_now(), 128'h0);
    t = zero_instr();
    t.alu = 32'h77; t.rd = 5'd2; t.rw = 1'b1;
    run_instr(t, 0, 32'hABCD);

    for (int i = 0; i < 80; i++) begin
      int k;
      k = $urandom_range(0, 9);
      if (k < 4)      t = rnd_instr(0);
      else if (k < 7) t = rnd_instr(1);
      else if (k < 9) t = rnd_instr(2);
      else            t = rnd_instr(3);
      run_instr(t, $urandom_range(0, 4), $urandom);
    end

`ifdef MEM_TIMEOUT_EN
    t = zero_instr();
    t.ld = 1'b1; t.alu = 32'h800; t.rd = 5'd4; t.rw = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(t);
      else        drive(zero_instr());
      mem_ack = 1'b0;
      #1;
      check_eq("to_stall", 128'(stall_o), 128'(c < 4));
      @(posedge clk);
      #1;
      check_eq("to_w", w_now(), 128'h0);
    end
    check_eq("to_err", 128'(mem_err), 128'h1);
    t = zero_instr();
    t.alu = 32'h99; t.rd = 5'd8; t.rw = 1'b1;
    run_instr(t, 0, 32'h0);
    check_eq("to_err_sticky", 128'(mem_err), 128'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits between the EXE->MEM pipeline register and the writeback stage.
- Issues the data-memory load/store for the M-stage instruction over a req/ack interface and holds the pipeline with stall_o while the access is outstanding.
- Registers the completed result into the MEM->WB outputs.
- Memory latency is variable: 0..N wait cycles.

Parameters:
- WIDTH, 32, data/address width.
- TIMEOUT_CYCLES, 64, WAIT-state cycle limit. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ALUResultM  in  WIDTH  effective address for memory ops, or ALU result.
- WriteDataM  in  WIDTH  store data.
- PCPlus4M  in  WIDTH  return address for jumps.
- RdM  in  5  destination register.
- RegWriteM, ResultSrcM, WDMEM, isLoadM, WD3SrcM  in  1 each  M-stage control signals. WDMEM is the store enable.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  WIDTH  word address.
- mem_wdata  out  WIDTH  store data.
- mem_ack  in  1  access complete. Read data is valid in the same cycle.
- mem_rdata  in  WIDTH  load data.
- stall_o  out  1  to hazard unit: freeze IF/ID/EX and bubble the EXE->MEM register.
- ReadDataW, ALUResultW, PCPlus4W  out  WIDTH  writeback data.
- RdW  out  5  writeback register index.
- RegWriteW, ResultSrcW, WD3SrcW  out  1 each  writeback controls.
- mem_err  out  1  sticky timeout flag. Present only with MEM_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - mem_req=0, stall_o=0.
  - All W outputs are 0, with RegWriteW=0.
  - mem_err=0.
  - Reset mid-WAIT drops mem_req immediately and discards the access; no writeback occurs.
- An access is defined as isLoadM | WDMEM. Both set at once is illegal; the load takes priority (mem_we=0).
- IDLE, no access: the next clock loads the W registers directly from the M inputs. ReadDataW=0. Latency is 1 cycle, with no stall.
- IDLE, access:
  - Same cycle (combinational): mem_req=1, mem_we=WDMEM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
  - A hold register captures all M inputs at the clock edge.
- If mem_ack=1 in the issue cycle:
  - stall_o=0.
  - W registers load on the same edge; ReadDataW=mem_rdata for loads, 0 for stores.
  - FSM stays in IDLE.
- If mem_ack=0 in the issue cycle:
  - stall_o=1 in that cycle.
  - FSM goes to WAIT.
  - W registers load a bubble: RegWriteW=0, RdW=0, other W outputs 0.
- WAIT:
  - mem_req/mem_we/mem_addr/mem_wdata are driven from the hold register and stay stable until ack.
  - M inputs are ignored; upstream presents NOP bubbles.
  - stall_o=1 while mem_ack=0.
  - In the ack cycle: stall_o=0, W registers load from the hold register plus mem_rdata, and FSM goes to IDLE.
- Back-to-back accesses: after an ack, the next M-stage access may issue in the following cycle (IDLE). There is no dead cycle.
- Stores write back nothing: RegWriteW follows the held RegWriteM, which the decoder guarantees is 0 for stores.
- A NOP bubble from upstream (RegWriteM=1, RdM=0) passes through as a write to x0, which is harmless.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- MEM_TIMEOUT_EN, defined:
  - A WAIT-cycle counter starts at 0 on entry to WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without ack, the access is aborted.
  - On abort: mem_req drops, mem_err is set (sticky until reset), W registers load a bubble, stall_o=0, FSM goes to IDLE.
- MEM_TIMEOUT_EN, undefined: no counter, no mem_err port, and WAIT persists indefinitely.

Decomposition:
- Shared package (pipeline_pkg):
  - mem_state_t enum {IDLE, WAIT}.
  - M-stage bundle struct (data + control), reused for the hold register.
  - W-stage bundle struct.
  - NOP/bubble constant for the W bundle.
- One natural sub-module, pipeline_MEMtoWB: the W register with load/bubble select, sitting alongside the req/ack FSM in this block.

Test Plan:
- Non-memory op: ALUResultM=0x10, RdM=5, RegWriteM=1, mem_ack unused -> next cycle ALUResultW=0x10, RdW=5, RegWriteW=1; stall_o never asserted.
- Load, zero-wait: isLoadM=1, ALUResultM=0x100, mem_ack=1 and mem_rdata=0xDEADBEEF in the same cycle -> mem_addr=0x100, stall_o=0, next cycle ReadDataW=0xDEADBEEF, RdW as given.
- Load, 3 wait cycles: ack on the 4th cycle -> stall_o high for 3 cycles; mem_addr held at 0x100 while M inputs change; W outputs are bubbles (RegWriteW=0) for 3 cycles, then the load result.
- Store, 2 wait cycles: WDMEM=1, ALUResultM=0x200, WriteDataM=0x12345678 -> mem_we=1 and mem_wdata stable until ack; RegWriteW=0 throughout; then a back-to-back load issues on the cycle after the ack.
- Reset mid-WAIT: rst_n=0 during WAIT -> mem_req=0 and stall_o=0 immediately; after release, FSM is in IDLE and no writeback of the aborted load occurs.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: no ack -> abort after 4 WAIT cycles; mem_err=1 (sticky), stall_o drops, pipeline resumes.
